// File: rtl/debounce_multicanal.sv
// debounce_multicanal: per-channel synchronise + stability-window debounce with rise/fall pulses and a lowest-index event port
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   din        raw switch/button inputs (active-low ones flagged in INV_MASK)
//   db         debounced, polarity-corrected levels
//   rise/fall  one-cycle pulses on a committed 0->1 / 1->0 change of db
//   evt_valid  any rise or fall this cycle
//   evt_idx    lowest channel index with an edge this cycle
//   evt_rise   1 = that edge is a rise, 0 = a fall
//   evt_multi  more than one channel committed this cycle
module debounce_multicanal #(
  parameter bit              SIMULACION   = 1'b0,
  parameter int              CLK_HZ       = 16_000_000,
  parameter int              DEBOUNCE_MS  = 10,
  parameter int              DB_TICKS_SIM = 2,
  parameter int              N_CH         = 16,
  parameter logic [N_CH-1:0] INV_MASK     = '0,
  localparam int             IDX_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  din,
  output logic [N_CH-1:0]  db,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx,
  output logic             evt_rise,
  output logic             evt_multi
);
  localparam int DB_TICKS = SIMULACION ? DB_TICKS_SIM : (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DB_TICKS - 1);
  logic [N_CH-1:0] meta_q, sync_q, db_q, db_d, rise_q, rise_d, fall_q, fall_d;
  logic [N_CH-1:0] e, e_low;
  logic [N_CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_d, evt_idx_q;
  logic evt_valid_q, evt_rise_q, evt_multi_q;
  // Counter only runs while the synchronised level disagrees with db; any agreement clears it.
  always_comb begin
    db_d = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync_q[i];
          rise_d[i] = sync_q[i];
          fall_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end
  // e_low isolates the lowest committing channel; anything left in e beyond it means a multi-commit.
  assign e = rise_d | fall_d;
  assign e_low = e & (~e + N_CH'(1));
  always_comb begin
    idx_d = '0;
    for (int i = N_CH - 1; i >= 0; i--) idx_d = e[i] ? IDX_W'(i) : idx_d;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      db_q <= '0;
      cnt_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q <= '0;
      evt_rise_q <= 1'b0;
      evt_multi_q <= 1'b0;
    end else begin
      meta_q <= din ^ INV_MASK;
      sync_q <= meta_q;
      db_q <= db_d;
      cnt_q <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_valid_q <= |e;
      evt_idx_q <= idx_d;
      evt_rise_q <= |(rise_d & e_low);
      evt_multi_q <= |(e & ~e_low);
    end
  end
  assign db = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign evt_valid = evt_valid_q;
  assign evt_idx = evt_idx_q;
  assign evt_rise = evt_rise_q;
  assign evt_multi = evt_multi_q;
endmodule

// File: tb/tb_debounce_multicanal.sv
// tb_debounce_multicanal: directed + random stimulus checked against a sample-window reference model
module tb_debounce_multicanal;
  localparam int DB = 2;
  localparam logic [15:0] MASK = 16'h8000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] din = 16'h8000;
  logic [15:0] db, rise, fall;
  logic evt_valid, evt_rise, evt_multi;
  logic [3:0] evt_idx;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] m_meta, m_sync, m_db, m_rise, m_fall;
  logic [15:0] m_hist [DB];
  logic m_valid, m_erise, m_multi;
  logic [3:0] m_idx;
  logic [15:0] seen;
  debounce_multicanal #(
    .SIMULACION(1'b1), .DB_TICKS_SIM(DB), .N_CH(16), .INV_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .db(db), .rise(rise), .fall(fall),
    .evt_valid(evt_valid), .evt_idx(evt_idx), .evt_rise(evt_rise), .evt_multi(evt_multi)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_meta = '0;
    m_sync = '0;
    m_db = '0;
    m_rise = '0;
    m_fall = '0;
    m_valid = 1'b0;
    m_idx = '0;
    m_erise = 1'b0;
    m_multi = 1'b0;
    for (int k = 0; k < DB; k++) m_hist[k] = '0;
  endtask
  // A channel takes value v once its last DB synchronised samples all equal v and v differs from db.
  task automatic model_edge();
    logic [15:0] s, nd, e;
    logic same;
    s = m_sync;
    for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s;
    nd = m_db;
    for (int i = 0; i < 16; i++) begin
      same = 1'b1;
      for (int k = 0; k < DB; k++) if (m_hist[k][i] != s[i]) same = 1'b0;
      if (same && s[i] != m_db[i]) nd[i] = s[i];
    end
    m_rise = nd & ~m_db;
    m_fall = ~nd & m_db;
    m_db = nd;
    e = m_rise | m_fall;
    m_valid = |e;
    m_idx = '0;
    for (int i = 15; i >= 0; i--) if (e[i]) m_idx = 4'(i);
    m_erise = m_rise[m_idx];
    m_multi = $countones(e) > 1;
    m_sync = m_meta;
    m_meta = din ^ MASK;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_model();
    chk("db", 32'(db), 32'(m_db));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("evt_valid", 32'(evt_valid), 32'(m_valid));
    chk("evt_idx", 32'(evt_idx), 32'(m_idx));
    chk("evt_rise", 32'(evt_rise), 32'(m_erise));
    chk("evt_multi", 32'(evt_multi), 32'(m_multi));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_db"}, 32'(db), 0);
    chk({tag, "_rise"}, 32'(rise), 0);
    chk({tag, "_fall"}, 32'(fall), 0);
    chk({tag, "_evt"}, {28'(0), evt_valid, evt_rise, evt_multi, |evt_idx}, 0);
  endtask
  task automatic tick(input logic [15:0] v);
    din = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask
  initial begin
    model_reset();
    #1 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = '0;
    for (int n = 0; n < 20; n++) begin
      tick(16'h8000);
      seen = seen | rise | fall | {15'(0), evt_valid} | db;
    end
    chk("idle_inv_released", 32'(seen), 0);
    tick(16'h8001);
    tick(16'h8001);
    tick(16'h8001);
    chk("ch0_not_yet", 32'(db[0]), 0);
    tick(16'h8001);
    chk("ch0_db", 32'(db), 32'h0001);
    chk("ch0_rise", 32'(rise), 32'h0001);
    chk("ch0_evt", {28'(0), evt_valid, evt_rise, evt_multi, 1'b0}, 32'hC);
    chk("ch0_idx", 32'(evt_idx), 0);
    tick(16'h8001);
    chk("ch0_one_pulse", 32'(rise | fall), 0);
    tick(16'h8009);
    for (int n = 0; n < 3; n++) tick(16'h8001);
    tick(16'h8009);
    for (int n = 0; n < 3; n++) tick(16'h8001);
    chk("glitch_no_commit", 32'(db[3]), 0);
    for (int n = 0; n < 3; n++) tick(16'h8009);
    chk("ch3_wait", 32'(db[3]), 0);
    tick(16'h8009);
    chk("ch3_commit", 32'(rise), 32'h0008);
    for (int n = 0; n < 3; n++) tick(16'h8209 | 16'h0004);
    tick(16'h820D);
    chk("multi_rise", 32'(rise), 32'h0204);
    chk("multi_idx", 32'(evt_idx), 2);
    chk("multi_flag", 32'(evt_multi), 1);
    for (int n = 0; n < 4; n++) tick(16'h020D);
    chk("ch15_press_db", 32'(db[15]), 1);
    for (int n = 0; n < 3; n++) tick(16'h820D);
    tick(16'h820D);
    chk("ch15_fall", 32'(fall), 32'h8000);
    chk("ch15_idx", 32'(evt_idx), 15);
    chk("ch15_evt_rise", 32'(evt_rise), 0);
    for (int n = 0; n < 3; n++) tick(16'h822D);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk);
    check_zero("held_reset");
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick(16'h822D);
      chk("rel_no_pulse", 32'(rise | fall), 0);
    end
    tick(16'h822D);
    chk("ch5_after_reset_db", 32'(db[5]), 1);
    tick(16'h822D);
    for (int n = 0; n < 400; n++) tick(din ^ 16'($urandom & $urandom & $urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
